// File: rtl/uart_autobaud_pkg.sv
// uart_autobaud_pkg: shared FSM encoding and calibration constants for the auto-baud block.
package uart_autobaud_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_HIGH, WAIT_EDGE, MEASURE, LOCKED} ab_state_t;
    localparam int CAL_EDGES = 5;
    localparam int CAL_SHIFT = 7;
    localparam int IDLE_HIGH_LEN = 16;
    localparam int DIV_W = 16;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: baud16 pulse generator, period equals the active divisor in clk cycles.
module uart_baud_gen
    import uart_autobaud_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             use_manual,
    input  logic [DIV_W-1:0] manual_div,
    input  logic [DIV_W-1:0] meas_div,
    input  logic             meas_valid,
    output logic             baud16_en,
    output logic [DIV_W-1:0] div_out
);
    logic [DIV_W-1:0] cnt, prev_div;
    logic run, run_q, reload;
    assign div_out = use_manual ? manual_div : meas_div;
    assign run = use_manual ? manual_div >= DIV_W'(2) : meas_valid;
    // a fresh start or a new divisor restarts the count without emitting a pulse
    assign reload = !run_q || div_out != prev_div;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            prev_div  <= '0;
            run_q     <= 1'b0;
            baud16_en <= 1'b0;
        end else begin
            prev_div  <= div_out;
            run_q     <= run;
            baud16_en <= run && !reload && cnt == '0;
            cnt       <= !run ? '0 : (reload || cnt == '0) ? div_out - 1'b1 : cnt - 1'b1;
        end
    end
endmodule

// File: rtl/uart_autobaud.sv
// uart_autobaud: measures the bit period from a 0x55 calibration character and drives a baud16 generator.
module uart_autobaud
    import uart_autobaud_pkg::*;
#(
    parameter int CNT_W = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_in,
    input  logic             arm,
    input  logic             use_manual,
    input  logic [DIV_W-1:0] manual_div,
    output logic             baud16_en,
    output logic             locked,
    output logic             busy,
    output logic             err,
    output logic [DIV_W-1:0] div_out
);
    ab_state_t state, state_n;
    logic rx_s1, rx_s, rx_d, fall;
    logic [CNT_W-1:0] cnt, cnt_n, q;
    logic [2:0] edges, edges_n;
    logic [3:0] hi_cnt, hi_n;
    logic [DIV_W-1:0] meas_div, div_n;
    logic meas_valid, valid_n, err_n;
    assign fall = rx_d & ~rx_s;
    assign q = cnt >> CAL_SHIFT;
    assign locked = state == LOCKED;
    assign busy = state inside {WAIT_HIGH, WAIT_EDGE, MEASURE};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {rx_d, rx_s, rx_s1} <= 3'b111;
            state      <= IDLE;
            cnt        <= '0;
            edges      <= '0;
            hi_cnt     <= '0;
            meas_div   <= '0;
            meas_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            {rx_d, rx_s, rx_s1} <= {rx_s, rx_s1, rx_in};
            state      <= state_n;
            cnt        <= cnt_n;
            edges      <= edges_n;
            hi_cnt     <= hi_n;
            meas_div   <= div_n;
            meas_valid <= valid_n;
            err        <= err_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        edges_n = edges;
        hi_n    = hi_cnt;
        div_n   = meas_div;
        valid_n = meas_valid;
        err_n   = err;
        if (arm) begin
            state_n = WAIT_HIGH;
            err_n   = 1'b0;
            edges_n = '0;
            hi_n    = '0;
        end else begin
            case (state)
                WAIT_HIGH: begin
                    hi_n = rx_s ? hi_cnt + 1'b1 : '0;
                    if (rx_s && hi_cnt == 4'(IDLE_HIGH_LEN - 1)) state_n = WAIT_EDGE;
                end
                WAIT_EDGE: if (fall) begin
                    state_n = MEASURE;
                    cnt_n   = CNT_W'(1);
                    edges_n = 3'd1;
                end
                MEASURE: begin
                    cnt_n   = cnt + 1'b1;
                    edges_n = fall ? edges + 1'b1 : edges;
                    // the fifth falling edge closes exactly eight bit periods
                    if (fall && edges == 3'(CAL_EDGES - 1)) begin
                        if (q >= CNT_W'(2)) begin
                            div_n   = DIV_W'(q);
                            valid_n = 1'b1;
                            state_n = LOCKED;
                        end else begin
                            err_n   = 1'b1;
                            state_n = IDLE;
                        end
                    end else if (cnt == '1) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
    uart_baud_gen u_gen (
        .clk(clk),
        .rst(rst),
        .use_manual(use_manual),
        .manual_div(manual_div),
        .meas_div(meas_div),
        .meas_valid(meas_valid),
        .baud16_en(baud16_en),
        .div_out(div_out)
    );
endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud: scoreboard bench; each measurement outcome is queued when its character is sent.
module tb_uart_autobaud;
    localparam int CNT_W = 14;
    typedef struct {int lk; int er; int dv;} exp_t;
    logic clk = 0, rst = 1, rx_in = 1, arm = 0, use_manual = 0, busy_q = 0;
    logic [15:0] manual_div = 0, div_out;
    logic baud16_en, locked, busy, err;
    exp_t sb[$];
    exp_t e;
    int checks = 0, errors = 0;
    uart_autobaud #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .arm(arm), .use_manual(use_manual),
        .manual_div(manual_div), .baud16_en(baud16_en), .locked(locked), .busy(busy),
        .err(err), .div_out(div_out)
    );
    always #5 clk = ~clk;
    task automatic check(string tag, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, act, exp);
        end
    endtask
    // a measurement ends whenever busy drops
    always @(negedge clk) begin
        busy_q <= busy;
        if (busy_q && !busy) begin
            if (sb.size() == 0) check("sb_empty", 0, 1);
            else begin
                e = sb.pop_front();
                check("locked", int'(locked), e.lk);
                check("err", int'(err), e.er);
                check("div_out", int'(div_out), e.dv);
            end
        end
    end
    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic do_arm;
        @(negedge clk) arm = 1;
        @(negedge clk) arm = 0;
        cycles(30);
    endtask
    task automatic send(int p, int nbits);
        logic [9:0] f = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx_in = f[i];
            cycles(p);
        end
        if (nbits == 9) begin
            rx_in = 1;
            cycles(20);
        end
    endtask
    task automatic wait_idle;
        int t = 0;
        while (busy && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask
    task automatic period(string tag, int exp);
        int t = 0;
        int n = -1;
        while (!baud16_en && t < 4 * exp + 10) begin
            @(negedge clk);
            t++;
        end
        if (baud16_en) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!baud16_en && n < 4 * exp + 10);
            if (!baud16_en) n = -1;
        end
        check(tag, n, exp);
    endtask
    initial begin
        #2ms;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int pulses;
        cycles(3);
        rst = 0;
        cycles(2);
        check("rst_locked", int'(locked), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_div", int'(div_out), 0);
        check("rst_baud", int'(baud16_en), 0);
        do_arm;
        sb.push_back('{0, 1, 0});
        rx_in = 0;
        cycles(2 ** CNT_W + 50);
        wait_idle;
        rx_in = 1;
        pulses = 0;
        repeat (300) begin
            @(negedge clk);
            if (baud16_en) pulses++;
        end
        check("no_pulse", pulses, 0);
        check("err_sticky", int'(err), 1);
        do_arm;
        check("err_clr", int'(err), 0);
        sb.push_back('{0, 1, 0});
        send(16, 9);
        wait_idle;
        do_arm;
        sb.push_back('{1, 0, 2});
        send(32, 9);
        wait_idle;
        do_arm;
        sb.push_back('{1, 0, 100});
        send(1600, 9);
        wait_idle;
        period("p100", 100);
        use_manual = 1;
        manual_div = 10;
        cycles(1);
        check("div_man", int'(div_out), 10);
        cycles(2);
        period("p10", 10);
        use_manual = 0;
        cycles(3);
        check("div_back", int'(div_out), 100);
        period("p100b", 100);
        do_arm;
        sb.push_back('{1, 0, 103});
        send(1650, 9);
        wait_idle;
        do_arm;
        sb.push_back('{0, 0, 0});
        send(1600, 5);
        rst = 1;
        cycles(2);
        check("abort_busy", int'(busy), 0);
        check("abort_locked", int'(locked), 0);
        check("abort_err", int'(err), 0);
        check("abort_baud", int'(baud16_en), 0);
        rx_in = 1;
        cycles(3);
        rst = 0;
        cycles(2);
        do_arm;
        sb.push_back('{1, 0, 100});
        send(1600, 9);
        wait_idle;
        period("p100c", 100);
        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
